// File: rtl/shift_sum_window_acc.sv
// shift_sum_window_acc
//   Windowed accumulator for the shift_and_sum 8-bit result bus. Sums the
//   low (adder) and high (shift) nibbles of WINDOW accepted samples, tracks
//   the largest low nibble, and offers the result over a valid/ready handshake.
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             request to open a new window (IDLE, or HOLD with res_ready)
//   in_data/in_valid  sample input; [7:4] shift nibble, [3:0] sum nibble
//   in_ready          a sample is accepted this cycle (state ACCUM)
//   res_valid/ready   result handshake (res_valid high in HOLD)
//   res_sum/shift/max windowed results, updated only when a window completes
//   busy              state != IDLE
//   drop              sticky: sample offered while not ready; cleared by start
module shift_sum_window_acc #(
    parameter int unsigned WINDOW = 8,
    parameter int unsigned ACC_W  = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_sum,
    output logic [ACC_W-1:0] res_shift,
    output logic [3:0]       res_max,
    output logic             busy,
    output logic             drop
);

    localparam int unsigned CNT_W = $clog2(WINDOW + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc_sum;
    logic [ACC_W-1:0]   acc_shift;
    logic [3:0]         acc_max;
    logic [CNT_W-1:0]   cnt;

    // Running values including the sample on in_data
    logic [ACC_W-1:0]   sum_next_c;
    logic [ACC_W-1:0]   shift_next_c;
    logic [3:0]         max_next_c;
    logic               last_c;

    always_comb begin
        sum_next_c   = acc_sum + ACC_W'(in_data[3:0]);
        shift_next_c = acc_shift + ACC_W'(in_data[7:4]);
        max_next_c   = (in_data[3:0] > acc_max) ? in_data[3:0] : acc_max;
        last_c       = (cnt == CNT_W'(WINDOW - 1));
    end

    // State machine, accumulators and registered status/result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc_sum   <= '0;
            acc_shift <= '0;
            acc_max   <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            drop      <= 1'b0;
            res_sum   <= '0;
            res_shift <= '0;
            res_max   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Start wins over a coincident sample: nothing accepted, drop cleared
                        state     <= ACCUM;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        drop      <= 1'b0;
                        acc_sum   <= '0;
                        acc_shift <= '0;
                        acc_max   <= '0;
                        cnt       <= '0;
                    end else if (in_valid) begin
                        drop <= 1'b1;
                    end
                end
                ACCUM: begin
                    // start is ignored here; only samples advance the window
                    if (in_valid) begin
                        acc_sum   <= sum_next_c;
                        acc_shift <= shift_next_c;
                        acc_max   <= max_next_c;
                        cnt       <= cnt + CNT_W'(1);
                        if (last_c) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            res_valid <= 1'b1;
                            res_sum   <= sum_next_c;
                            res_shift <= shift_next_c;
                            res_max   <= max_next_c;
                        end
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (start) begin
                            state     <= ACCUM;
                            in_ready  <= 1'b1;
                            drop      <= 1'b0;
                            acc_sum   <= '0;
                            acc_shift <= '0;
                            acc_max   <= '0;
                            cnt       <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (in_valid) begin
                                drop <= 1'b1;
                            end
                        end
                    end else if (in_valid) begin
                        drop <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sum_window_acc.sv
// Directed bench for shift_sum_window_acc with WINDOW=4, ACC_W=6.
module tb_shift_sum_window_acc;

    localparam int unsigned WINDOW = 4;
    localparam int unsigned ACC_W  = 6;

    logic             clk;
    logic             reset;
    logic             start;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_sum;
    logic [ACC_W-1:0] res_shift;
    logic [3:0]       res_max;
    logic             busy;
    logic             drop;

    int checks   = 0;
    int failures = 0;

    shift_sum_window_acc #(.WINDOW(WINDOW), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_shift (res_shift),
        .res_max   (res_max),
        .busy      (busy),
        .drop      (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic start_win();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic take_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic check_res(input string tag, input int s, input int sh, input int m);
        check({tag, "_valid"}, 32'(res_valid), 32'd1);
        check({tag, "_sum"},   32'(res_sum),   32'(s));
        check({tag, "_shift"}, 32'(res_shift), 32'(sh));
        check({tag, "_max"},   32'(res_max),   32'(m));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_data = 8'h00; in_valid = 1'b0; res_ready = 1'b0;
        tick(); tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        check("rst_res", {14'd0, res_sum, res_shift, res_max}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: basic window
        start_win();
        check("t1_in_ready", 32'(in_ready), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        send(8'h12); send(8'h34); send(8'h56);
        check("t1_not_yet", 32'(res_valid), 32'd0);
        send(8'h78);
        check_res("t1", 20, 16, 8);
        check("t1_in_ready_hold", 32'(in_ready), 32'd0);
        take_result();
        check("t1_idle_valid", 32'(res_valid), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_keep", 32'(res_sum), 32'd20);

        // 2: saturating input with idle gaps
        start_win();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin tick(); tick(); end
            send(8'hFF);
        end
        check_res("t2", 60, 60, 15);

        // 3: backpressure with a sample offered during HOLD
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin in_valid = 1'b1; in_data = 8'h99; end
            tick();
            in_valid = 1'b0;
        end
        check_res("t3", 60, 60, 15);
        check("t3_in_ready", 32'(in_ready), 32'd0);
        check("t3_drop", 32'(drop), 32'd1);
        take_result();
        check("t3_idle_valid", 32'(res_valid), 32'd0);
        check("t3_idle_busy", 32'(busy), 32'd0);
        check("t3_drop_kept", 32'(drop), 32'd1);
        start_win();
        check("t3_drop_clr", 32'(drop), 32'd0);
        for (int i = 0; i < 4; i++) send(8'h12);
        check_res("t3b", 8, 4, 2);

        // 4: back-to-back restart from HOLD
        res_ready = 1'b1; start = 1'b1;
        tick();
        res_ready = 1'b0; start = 1'b0;
        check("t4_in_ready", 32'(in_ready), 32'd1);
        check("t4_valid", 32'(res_valid), 32'd0);
        check("t4_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) send(8'h01);
        check_res("t4", 4, 0, 1);
        take_result();

        // IDLE drop behaviour: lone sample sets drop, start+sample clears it
        in_valid = 1'b1; in_data = 8'h44;
        tick();
        check("idle_drop", 32'(drop), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b0;
        check("start_drop_clr", 32'(drop), 32'd0);
        check("start_in_ready", 32'(in_ready), 32'd1);

        // 5: reset mid-window, then a fresh window
        send(8'h33); send(8'h33);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_in_ready", 32'(in_ready), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_valid", 32'(res_valid), 32'd0);
        check("t5_res", {14'd0, res_sum, res_shift, res_max}, 32'd0);
        start_win();
        for (int i = 0; i < 4; i++) send(8'h11);
        check_res("t5", 4, 4, 1);
        take_result();

        // 6: start mid-ACCUM is ignored
        start_win();
        send(8'h21); send(8'h43);
        start_win();
        check("t6_in_ready", 32'(in_ready), 32'd1);
        send(8'h65);
        check("t6_not_yet", 32'(res_valid), 32'd0);
        send(8'h87);
        check_res("t6", 16, 20, 7);
        take_result();
        check("t6_idle_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
